// File: rtl/mac_vector_engine.sv
`default_nettype none
// ============================================================================
// Module   : mac_vector_engine
// Purpose  : Serially loads a data vector and a weight vector, computes their
//            signed or unsigned dot product, then overwrites or accumulates it
//            into a wide accumulator. The accumulator is streamed out LSB chunk
//            first under a valid/ready handshake.
// Ports    : clk, rst_n (sync, active-low)
//            in_data/in_valid/in_sel  - element loader (IDLE only)
//            start/acc_clear/signed_mode - compute launch and its modes
//            out_data/out_valid/out_ready/out_last - result chunk stream
//            busy - high whenever the engine is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module mac_vector_engine #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic             start,
  input  logic             acc_clear,
  input  logic             signed_mode,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int NCHUNK = (ACC_W + OUT_W - 1) / OUT_W;
  localparam int PAD_W  = NCHUNK * OUT_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW     = 2 * DW;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DW-1:0]    r_data   [LANES];
  logic [DW-1:0]    r_weight [LANES];
  logic [PW-1:0]    r_prod   [LANES];
  logic [PW-1:0]    w_prod   [LANES];
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic [PAD_W-1:0] w_acc_pad;
  logic [IDX_W-1:0] r_idx;
  logic             r_signed;
  logic             r_clear;

  logic w_load;
  logic w_start;
  logic w_xfer;

  assign w_load  = (r_state == S_IDLE) && in_valid;
  assign w_start = (r_state == S_IDLE) && start;
  assign w_xfer  = (r_state == S_OUT) && out_ready;

  // Each lane multiplies 2*DW-bit extended operands and keeps the low 2*DW
  // bits; that truncation is exact for both two's-complement and unsigned.
  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [PW-1:0] w_a_ext;
      logic [PW-1:0] w_b_ext;
      assign w_a_ext  = {{DW{r_signed & r_data[g][DW-1]}},   r_data[g]};
      assign w_b_ext  = {{DW{r_signed & r_weight[g][DW-1]}}, r_weight[g]};
      assign w_prod[g] = w_a_ext * w_b_ext;
    end
  endgenerate

  // Adder tree over the registered products, each extended to ACC_W.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + {{(ACC_W-PW){r_signed & r_prod[i][PW-1]}}, r_prod[i]};
    end
  end

  // Zero-padding above ACC_W lets the final chunk be a plain part-select.
  assign w_acc_pad = PAD_W'(r_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_MUL;
      S_MUL:  w_state_next = S_ACC;
      S_ACC:  w_state_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        out_last  = (r_idx == C_LAST_IDX);
        out_data  = w_acc_pad[r_idx*OUT_W +: OUT_W];
        if (out_ready && (r_idx == C_LAST_IDX)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        r_data[i]   <= '0;
        r_weight[i] <= '0;
        r_prod[i]   <= '0;
      end
      r_acc    <= '0;
      r_idx    <= '0;
      r_signed <= 1'b0;
      r_clear  <= 1'b0;
    end else begin
      // Shift register load: lane 0 takes the new element.
      if (w_load) begin
        if (in_sel) begin
          for (int i = LANES-1; i > 0; i--) r_weight[i] <= r_weight[i-1];
          r_weight[0] <= in_data;
        end else begin
          for (int i = LANES-1; i > 0; i--) r_data[i] <= r_data[i-1];
          r_data[0] <= in_data;
        end
      end

      if (w_start) begin
        r_signed <= signed_mode;
        r_clear  <= acc_clear;
      end

      if (r_state == S_MUL) begin
        for (int i = 0; i < LANES; i++) r_prod[i] <= w_prod[i];
      end

      if (r_state == S_ACC) begin
        r_acc <= r_clear ? w_sum : (r_acc + w_sum);
        r_idx <= '0;
      end

      if (w_xfer && (r_idx != C_LAST_IDX)) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_vector_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_vector_engine
// Purpose  : Directed self-checking bench for mac_vector_engine with default
//            parameters (4 lanes, 8-bit elements, 24-bit acc, 8-bit chunks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_vector_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sel;
  logic       start;
  logic       acc_clear;
  logic       signed_mode;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] r_chunk [3];
  logic       r_last  [3];
  int         r_lat;
  logic       r_timeout;

  always #5 clk = ~clk;

  mac_vector_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sel      (in_sel),
    .start       (start),
    .acc_clear   (acc_clear),
    .signed_mode (signed_mode),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Elements go in a, b, c, d order; d ends up in lane 0.
  task automatic load4(input logic sel, input logic [7:0] a, b, c, d);
    push(sel, a);
    push(sel, b);
    push(sel, c);
    push(sel, d);
  endtask

  task automatic pulse_start(input logic clr, input logic sgn);
    start       = 1'b1;
    acc_clear   = clr;
    signed_mode = sgn;
    tick();
    start       = 1'b0;
    acc_clear   = 1'b0;
    signed_mode = 1'b0;
  endtask

  // Gathers one full result stream with out_ready high; no checking here.
  task automatic collect();
    r_lat     = 0;
    r_timeout = 1'b0;
    while (!out_valid && r_lat < 10) begin
      tick();
      r_lat++;
    end
    for (int k = 0; k < 3; k++) begin
      if (!out_valid) r_timeout = 1'b1;
      r_chunk[k] = out_data;
      r_last[k]  = out_last;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({out_valid, out_last, busy, out_data} !== 11'd0) begin
      n_err++;
      $display("FAIL reset outputs: got v=%b l=%b b=%b d=%h want all 0",
               out_valid, out_last, busy, out_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    logic [7:0] exp_c [3] = '{8'h46, 8'h00, 8'h00};
    load4(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
    load4(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
    pulse_start(1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL unsigned MUL state: got v=%b busy=%b want v=0 busy=1", out_valid, busy);
    end
    collect();
    n_vec++;
    if (r_timeout || r_lat != 2) begin
      n_err++;
      $display("FAIL unsigned latency: got %0d timeout=%b want 2", r_lat, r_timeout);
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({r_last[k], r_chunk[k]} !== {(k == 2), exp_c[k]}) begin
        n_err++;
        $display("FAIL unsigned chunk%0d: got last=%b %h want last=%b %h",
                 k, r_last[k], r_chunk[k], (k == 2), exp_c[k]);
      end
    end
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL unsigned done: got busy=%b v=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] exp_a [3] = '{8'h8C, 8'h00, 8'h00};
    logic [7:0] exp_b [3] = '{8'h46, 8'h00, 8'h00};
    pulse_start(1'b0, 1'b0);
    collect();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (r_timeout || {r_last[k], r_chunk[k]} !== {(k == 2), exp_a[k]}) begin
        n_err++;
        $display("FAIL accumulate chunk%0d: got last=%b %h want last=%b %h",
                 k, r_last[k], r_chunk[k], (k == 2), exp_a[k]);
      end
    end
    pulse_start(1'b1, 1'b0);
    collect();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (r_timeout || {r_last[k], r_chunk[k]} !== {(k == 2), exp_b[k]}) begin
        n_err++;
        $display("FAIL reclear chunk%0d: got last=%b %h want last=%b %h",
                 k, r_last[k], r_chunk[k], (k == 2), exp_b[k]);
      end
    end
  endtask

  // The final weight load shares its cycle with start; the compute must see it.
  task automatic test_max();
    logic [7:0] exp_c [3] = '{8'h04, 8'hF8, 8'h03};
    load4(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push(1'b1, 8'hFF);
    push(1'b1, 8'hFF);
    push(1'b1, 8'hFF);
    in_valid = 1'b1;
    in_sel   = 1'b1;
    in_data  = 8'hFF;
    pulse_start(1'b1, 1'b0);
    in_valid = 1'b0;
    collect();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (r_timeout || {r_last[k], r_chunk[k]} !== {(k == 2), exp_c[k]}) begin
        n_err++;
        $display("FAIL max chunk%0d: got last=%b %h want last=%b %h",
                 k, r_last[k], r_chunk[k], (k == 2), exp_c[k]);
      end
    end
  endtask

  task automatic test_signed();
    logic [7:0] exp_s [3] = '{8'hF8, 8'hFF, 8'hFF};
    logic [7:0] exp_u [3] = '{8'hF8, 8'h07, 8'h00};
    load4(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    load4(1'b1, 8'h02, 8'h02, 8'h02, 8'h02);
    pulse_start(1'b1, 1'b1);
    collect();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (r_timeout || {r_last[k], r_chunk[k]} !== {(k == 2), exp_s[k]}) begin
        n_err++;
        $display("FAIL signed chunk%0d: got last=%b %h want last=%b %h",
                 k, r_last[k], r_chunk[k], (k == 2), exp_s[k]);
      end
    end
    pulse_start(1'b1, 1'b0);
    collect();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (r_timeout || {r_last[k], r_chunk[k]} !== {(k == 2), exp_u[k]}) begin
        n_err++;
        $display("FAIL signed-as-unsigned chunk%0d: got last=%b %h want last=%b %h",
                 k, r_last[k], r_chunk[k], (k == 2), exp_u[k]);
      end
    end
  endtask

  // Vectors are FF / 02 here; unsigned clear gives 0x0007F8.
  task automatic test_backpressure();
    logic [7:0] exp_s [3] = '{8'hF8, 8'hFF, 8'hFF};
    int lat;
    pulse_start(1'b1, 1'b0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'hF8 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL bp chunk0: got v=%b %h last=%b want v=1 f8 last=0", out_valid, out_data, out_last);
    end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start    = 1'b1;
      in_valid = 1'b1;
      in_sel   = i[0];
      in_data  = 8'h55;
      tick();
      n_vec++;
      if ({out_valid, out_last, busy, out_data} !== {1'b1, 1'b0, 1'b1, 8'h07}) begin
        n_err++;
        $display("FAIL bp hold%0d: got v=%b l=%b b=%b %h want v=1 l=0 b=1 07",
                 i, out_valid, out_last, busy, out_data);
      end
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_vec++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL bp chunk2: got v=%b l=%b %h want v=1 l=1 00", out_valid, out_last, out_data);
    end
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp ignored start: got busy=%b v=%b want 0 0", busy, out_valid);
    end
    pulse_start(1'b1, 1'b1);
    collect();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (r_timeout || {r_last[k], r_chunk[k]} !== {(k == 2), exp_s[k]}) begin
        n_err++;
        $display("FAIL bp vectors kept chunk%0d: got last=%b %h want last=%b %h",
                 k, r_last[k], r_chunk[k], (k == 2), exp_s[k]);
      end
    end
  endtask

  task automatic test_reset_mid_out();
    int lat;
    pulse_start(1'b1, 1'b0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({out_valid, out_last, busy, out_data} !== 11'd0) begin
      n_err++;
      $display("FAIL midout reset: got v=%b l=%b b=%b %h want all 0",
               out_valid, out_last, busy, out_data);
    end
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midout no partial: got v=%b b=%b want 0 0", out_valid, busy);
    end
    pulse_start(1'b0, 1'b0);
    collect();
    n_vec++;
    if (r_timeout || r_lat != 2) begin
      n_err++;
      $display("FAIL post-reset latency: got %0d timeout=%b want 2", r_lat, r_timeout);
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({r_last[k], r_chunk[k]} !== {(k == 2), 8'h00}) begin
        n_err++;
        $display("FAIL post-reset chunk%0d: got last=%b %h want last=%b 00",
                 k, r_last[k], r_chunk[k], (k == 2));
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    in_sel      = 1'b0;
    start       = 1'b0;
    acc_clear   = 1'b0;
    signed_mode = 1'b0;
    out_ready   = 1'b1;
    test_reset();
    test_unsigned();
    test_accumulate();
    test_max();
    test_signed();
    test_backpressure();
    test_reset_mid_out();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
